// File: rtl/tug_of_war_ctrl.sv
// Round sequencer for the tug-of-war light field: turns player keys into
// single-cycle move pulses, scores points when the light leaves either end,
// holds the result, restarts the field and stops the match at WIN_SCORE.
module tug_of_war_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               keyL,
    input  logic               keyR,
    input  logic               leftEnd,
    input  logic               rightEnd,
    output logic               L,
    output logic               R,
    output logic               freset,
    output logic [SCORE_W-1:0] scoreL,
    output logic [SCORE_W-1:0] scoreR,
    output logic [1:0]         winner,
    output logic               gameOver
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] S_PLAY    = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_RESTART = 2'd2;
    localparam logic [1:0] S_OVER    = 2'd3;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] scoreL_q, scoreL_d;
    logic [SCORE_W-1:0] scoreR_q, scoreR_d;
    logic [1:0]         winner_q, winner_d;
    logic               L_q, L_d;
    logic               R_q, R_d;
    logic               prevL_q, prevR_q;
    logic               point_l, point_r;

    // Scores stop at the counter maximum instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

    // A point is scored by the pulse currently on the field; a simultaneous
    // L/R pair is a tie and never scores.
    assign point_l = L_q & ~R_q & leftEnd;
    assign point_r = R_q & ~L_q & rightEnd;

    // Next-state logic for the round sequencer, pulses and scores.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        scoreL_d = scoreL_q;
        scoreR_d = scoreR_q;
        winner_d = winner_q;
        L_d      = 1'b0;
        R_d      = 1'b0;
        case (state_q)
            S_PLAY: begin
                L_d = keyL & ~prevL_q;
                R_d = keyR & ~prevR_q;
                if (point_l) begin
                    scoreL_d = sat_inc(scoreL_q);
                    winner_d = 2'b01;
                    // No new pulse may start into the held result.
                    L_d      = 1'b0;
                    R_d      = 1'b0;
                    if (scoreL_d == WIN_VAL) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else if (point_r) begin
                    scoreR_d = sat_inc(scoreR_q);
                    winner_d = 2'b10;
                    L_d      = 1'b0;
                    R_d      = 1'b0;
                    if (scoreR_d == WIN_VAL) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_RESTART;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESTART: begin
                state_d  = S_PLAY;
                winner_d = 2'b00;
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_PLAY;
            end
        endcase
    end

    // State registers; previous key levels track the keys in every state so
    // a key held across reset or a restart never yields a pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_PLAY;
            cnt_q    <= '0;
            scoreL_q <= '0;
            scoreR_q <= '0;
            winner_q <= 2'b00;
            L_q      <= 1'b0;
            R_q      <= 1'b0;
            prevL_q  <= 1'b1;
            prevR_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            scoreL_q <= scoreL_d;
            scoreR_q <= scoreR_d;
            winner_q <= winner_d;
            L_q      <= L_d;
            R_q      <= R_d;
            prevL_q  <= keyL;
            prevR_q  <= keyR;
        end
    end

    assign L        = L_q;
    assign R        = R_q;
    assign freset   = (state_q == S_RESTART);
    assign gameOver = (state_q == S_OVER);
    assign scoreL   = scoreL_q;
    assign scoreR   = scoreR_q;
    assign winner   = winner_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Bench for tug_of_war_ctrl: a cycle-numbered behavioural model checked
// against the DUT every cycle, plus directed scenarios with literal checks.
module tb_tug_of_war_ctrl;

    localparam int H    = 4;
    localparam int WIN  = 7;
    localparam int SW   = 3;
    localparam int MAXS = 7;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          keyL = 1'b0, keyR = 1'b0, leftEnd = 1'b0, rightEnd = 1'b0;
    logic          L, R, freset, gameOver;
    logic [SW-1:0] scoreL, scoreR;
    logic [1:0]    winner;

    int n_checks = 0;
    int n_fail   = 0;

    tug_of_war_ctrl #(.WIN_SCORE(WIN), .HOLD_CYCLES(H), .SCORE_W(SW)) dut (
        .Clock(Clock), .Reset(Reset), .keyL(keyL), .keyR(keyR),
        .leftEnd(leftEnd), .rightEnd(rightEnd), .L(L), .R(R), .freset(freset),
        .scoreL(scoreL), .scoreR(scoreR), .winner(winner), .gameOver(gameOver)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a point at edge c freezes play; freset is high after edge c+H,
    // the winner clears at edge c+H+1, and keys count again from edge c+H+2.
    int   cyc = 0;
    int   fres_at = -100, resume = 0;
    logic m_started = 1'b0;
    logic mL = 1'b0, mR = 1'b0, mprevL = 1'b1, mprevR = 1'b1, mover = 1'b0, mfres = 1'b0;
    int   msL = 0, msR = 0, mwin = 0;

    always @(posedge Clock) begin : model
        logic playing, nl, nr, over, fr;
        int   sl, sr, win, fa, rs;
        if (Reset) begin
            m_started <= 1'b1;
            mL <= 1'b0; mR <= 1'b0; mprevL <= 1'b1; mprevR <= 1'b1;
            msL <= 0; msR <= 0; mwin <= 0; mover <= 1'b0; mfres <= 1'b0;
            fres_at <= -100; resume <= 0;
        end else begin
            sl = msL; sr = msR; win = mwin; over = mover; fa = fres_at; rs = resume;
            playing = !over && (cyc >= rs);
            nl = playing && keyL && !mprevL;
            nr = playing && keyR && !mprevR;
            if (playing && mL && !mR && leftEnd) begin
                sl = (sl < MAXS) ? sl + 1 : sl;
                win = 1; nl = 1'b0; nr = 1'b0;
                if (sl == WIN) over = 1'b1;
                else begin fa = cyc + H; rs = cyc + H + 2; end
            end else if (playing && mR && !mL && rightEnd) begin
                sr = (sr < MAXS) ? sr + 1 : sr;
                win = 2; nl = 1'b0; nr = 1'b0;
                if (sr == WIN) over = 1'b1;
                else begin fa = cyc + H; rs = cyc + H + 2; end
            end
            if (cyc == fa + 1) win = 0;
            fr = !over && (cyc == fa);
            mL <= nl; mR <= nr; mprevL <= keyL; mprevR <= keyR;
            msL <= sl; msR <= sr; mwin <= win; mover <= over; mfres <= fr;
            fres_at <= fa; resume <= rs;
        end
        cyc <= cyc + 1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    int cntL = 0, cntR = 0, cntF = 0;
    always @(negedge Clock) begin
        if (m_started) begin
            chk("L", int'(L), int'(mL));
            chk("R", int'(R), int'(mR));
            chk("freset", int'(freset), int'(mfres));
            chk("gameOver", int'(gameOver), int'(mover));
            chk("scoreL", int'(scoreL), msL);
            chk("scoreR", int'(scoreR), msR);
            chk("winner", int'(winner), mwin);
        end
        if (L) cntL++;
        if (R) cntR++;
        if (freset) cntF++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge Clock);
            #1;
        end
    endtask

    initial begin
        int c, c2;
        // Reset with keyL held: no pulse until released and pressed again.
        keyL = 1'b1;
        tick(3);
        Reset = 1'b0;
        chk("reset_all_zero", int'({L, R, freset, scoreL, scoreR, winner, gameOver}), 0);
        c = cntL;
        tick(4);
        chk("held_through_reset_no_L", cntL - c, 0);
        keyL = 1'b0;
        tick(2);
        c = cntL;
        keyL = 1'b1;
        tick(1);
        chk("L_after_sample", int'(L), 1);
        tick(4);
        keyL = 1'b0;
        tick(2);
        chk("L_single_pulse", cntL - c, 1);
        c = cntR;
        keyR = 1'b1;
        tick(1);
        chk("R_after_sample", int'(R), 1);
        tick(4);
        keyR = 1'b0;
        tick(2);
        chk("R_single_pulse", cntR - c, 1);

        // Left point, hold, restart.
        leftEnd = 1'b1;
        keyL = 1'b1;
        tick(1);
        chk("point_pulse_L", int'(L), 1);
        tick(1);
        chk("point_scoreL", int'(scoreL), 1);
        chk("point_winner", int'(winner), 1);
        tick(4);
        chk("restart_freset", int'(freset), 1);
        keyL = 1'b0;
        tick(1);
        chk("play_freset_low", int'(freset), 0);
        chk("play_winner_clear", int'(winner), 0);
        leftEnd = 1'b0;
        tick(2);

        // Tie: both keys rise together with both ends lit.
        leftEnd = 1'b1; rightEnd = 1'b1;
        keyL = 1'b1; keyR = 1'b1;
        tick(1);
        chk("tie_both_pulses", int'({L, R}), 3);
        tick(1);
        chk("tie_no_score", int'({scoreL, scoreR, winner}), (1 << 5));
        keyL = 1'b0; keyR = 1'b0;
        leftEnd = 1'b0; rightEnd = 1'b0;
        tick(2);

        // Seven right points end the match.
        rightEnd = 1'b1;
        c = cntF;
        for (int i = 0; i < WIN; i++) begin
            keyR = 1'b1;
            tick(2);
            keyR = 1'b0;
            tick(H + 2);
        end
        chk("match_scoreR", int'(scoreR), 7);
        chk("match_gameOver", int'(gameOver), 1);
        chk("match_freset_count", cntF - c, WIN - 1);
        c = cntR; c2 = cntL;
        leftEnd = 1'b1;
        keyR = 1'b1; keyL = 1'b1;
        tick(3);
        keyR = 1'b0; keyL = 1'b0;
        tick(1);
        keyR = 1'b1;
        tick(3);
        chk("over_no_R", cntR - c, 0);
        chk("over_no_L", cntL - c2, 0);
        chk("over_scores_frozen", int'({scoreL, scoreR}), (1 << 3) | 7);
        keyR = 1'b0; leftEnd = 1'b0; rightEnd = 1'b0;
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        chk("reset_from_over", int'({L, R, freset, scoreL, scoreR, winner, gameOver}), 0);
        tick(2);

        // Reset during the second HOLD cycle.
        leftEnd = 1'b1;
        keyL = 1'b1;
        tick(3);
        chk("hold_scoreL", int'(scoreL), 1);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        chk("midhold_reset", int'({freset, scoreL, scoreR, winner, gameOver}), 0);
        keyL = 1'b0; leftEnd = 1'b0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tug_of_war_ctrl.md
# tug_of_war_ctrl

Round sequencer for the tug-of-war light field. It converts the two synchronized player keys into single-cycle move pulses and drives those pulses onto the field's `L`/`R` inputs. It detects when the light is pushed off either end of the field, keeps a saturating score per player, holds the result briefly, and then restarts the field through `freset`. The block sits between the key synchronizers and the light-field instance, and drives the score displays and the game-over indicator.

## Interface
Parameters:
- `WIN_SCORE`, default 7: score that ends the match. Legal range 1..2^`SCORE_W`-1.
- `HOLD_CYCLES`, default 4: number of cycles the round result is held before the field restarts. Must be ≥1.
- `SCORE_W`, default 3: width of each score counter.

Ports:
- `Clock` in 1: single system clock; all state updates on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `keyL` in 1: left player key, level, already synchronized to `Clock`.
- `keyR` in 1: right player key, level, already synchronized to `Clock`.
- `leftEnd` in 1: the leftmost field light is on.
- `rightEnd` in 1: the rightmost field light is on.
- `L` out 1: left move pulse to the field.
- `R` out 1: right move pulse to the field.
- `freset` out 1: field restart; the field returns the light to the center.
- `scoreL` out `SCORE_W`: left player score.
- `scoreR` out `SCORE_W`: right player score.
- `winner` out 2: last round winner. 00 = none, 01 = left, 10 = right.
- `gameOver` out 1: match finished.

## Operation
States:
- PLAY: normal play.
- HOLD: result display.
- RESTART: one-cycle field restart.
- OVER: match finished, terminal until `Reset`.

Edge detection:
- Registers `prevL`/`prevR` hold the previous key values.
- `L` and `R` are registered. `L` is set after an edge where state is PLAY, `keyL`=1 and `prevL`=0; otherwise `L` is 0. `R` follows the same rule with `keyR`/`prevR`.
- `prevL`/`prevR` update every cycle in every state, so a key held across a restart produces no pulse.

Win detection (PLAY only), evaluated at each edge on the current `L`/`R`:
- Left point: `L`=1, `R`=0, `leftEnd`=1.
- Right point: `R`=1, `L`=0, `rightEnd`=1.
- `L`=`R`=1: no move and no point, matching the field's tie rule.

On a point:
- The winner's score increments, saturating at 2^`SCORE_W`-1.
- `winner` is set to 01 (left) or 10 (right).
- If the new score equals `WIN_SCORE`, the next state is OVER; otherwise the next state is HOLD with the hold counter loaded to `HOLD_CYCLES`-1.

HOLD:
- `L`/`R` are forced to 0.
- The counter decrements each cycle; at 0 the next state is RESTART.

RESTART:
- `freset`=1 for exactly this one cycle.
- Next state is PLAY, and `winner` returns to 00 on entry to PLAY.

OVER:
- `gameOver`=1; `L`/`R`/`freset` are 0.
- Scores and `winner` stay frozen.
- Only `Reset` leaves this state.

## Timing
Reset values (after any edge with `Reset`=1):
- State PLAY.
- `L`=`R`=`freset`=0, `scoreL`=`scoreR`=0, `winner`=00, `gameOver`=0.
- `prevL`=`prevR`=1, so a key held through reset produces no pulse.
- `Reset` has priority over every transition, including mid-HOLD and the RESTART cycle. The field is reset by `Reset` directly, so `freset` is not asserted for it.

Latencies:
- Key rise sampled at edge k gives `L`/`R` high for the cycle after edge k.
- A point is detected at edge k+1; `scoreX`/`winner` update at edge k+1.
- HOLD lasts `HOLD_CYCLES` cycles, then `freset` is high for 1 cycle, then PLAY.
- A winning press reaches PLAY again `HOLD_CYCLES`+2 edges after the key was sampled.

Boundary rules:
- A pulse that scores a point is still presented to the field in that cycle, so the end light turns off.
- A key pressed during HOLD, RESTART or OVER is discarded; it does not queue.
- Both end inputs high at once is illegal from the field. The controller still scores by the pulse direction only.
- Scores never wrap.

## Test plan
- Reset with `keyL` held high: `L` stays 0 until the key is released and pressed again. All outputs read 0 after reset.
- `keyL` held 5 cycles: exactly one `L` pulse, 1 cycle wide, in the cycle after the key is sampled. The same check applies to `keyR`/`R`.
- `leftEnd`=1 and a `keyL` press: `scoreL` goes 0→1 and `winner`=01 at the following edge. Then 4 cycles of HOLD with `L`/`R`=0, then `freset`=1 for 1 cycle, then PLAY with `winner`=00.
- `keyL` and `keyR` rise in the same cycle with `leftEnd`=`rightEnd`=1: `L`=`R`=1 for one cycle, no score change, state stays PLAY.
- Seven right points with `rightEnd`=1: `scoreR`=7, `gameOver`=1, and no further `freset`. Later presses change nothing; `Reset` restores all zeros.
- `Reset` asserted during the second HOLD cycle: at the next edge the state is PLAY, scores are 0 and `freset` is 0.
